radix4_booth_mult: RTL and testbench

Sequential signed 8×8 multiplier using radix-4 (modified) Booth recoding, producing a 16-bit two's-complement product. Both operands arrive serially over one shared 8-bit input bus after a start request. The result is presented on a 16-bit output bus with a completion flag. The block is intended as a small arithmetic unit driven by a controller or testbench over a simple start/stop handshake.

---
 rtl/radix4_booth_mult.sv | 145 ++++++++++++++
 tb/tb_radix4_booth_mult.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/radix4_booth_mult.sv
// radix4_booth_mult
// Sequential signed 8x8 multiplier using radix-4 (modified) Booth recoding.
// Both operands arrive serially on one 8-bit bus after a start request:
// multiplicand first, then multiplier. Four Booth steps follow. The 16-bit
// two's-complement product is then registered on outbus and flagged by stop.
//
// Ports
//   clk     in   1   system clock, rising-edge active
//   rst     in   1   synchronous active-high reset
//   start   in   1   operation request, honoured only in IDLE
//   inbus   in   8   signed operand bus (multiplicand, then multiplier)
//   outbus  out  16  signed product, registered, held until next completion
//   stop    out  1   high while the product is valid (DONE)
module radix4_booth_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  inbus,
  output logic [15:0] outbus,
  output logic        stop
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_Q = 2'd1,
    ITER   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  // Booth datapath: 10-bit accumulator A, multiplier Q, appended bit q_m1.
  logic [9:0]  a_reg;
  logic [7:0]  q_reg;
  logic [7:0]  m_reg;
  logic        q_m1;
  logic [1:0]  count;

  logic [9:0]  m_ext;
  logic [9:0]  m_dbl;
  logic [9:0]  addend;
  logic [9:0]  sum;
  logic [18:0] shifted;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE is left only once stop is already high, so the
  // valid product is always visible for at least one cycle even if start
  // has already been released by the time the result arrives.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD_Q;
        end
      end
      LOAD_Q: begin
        state_next = ITER;
      end
      ITER: begin
        if (count == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (stop && !start) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Booth recoding of {Q[1],Q[0],q_m1} into an addend of 0, +-M or +-2M,
  // followed by the 2-bit arithmetic right shift of the whole {A,Q,q_m1}
  // word. Ten bits of A leave room for +2*128 without overflow.
  always_comb begin
    m_ext  = {{2{m_reg[7]}}, m_reg};
    m_dbl  = {m_ext[8:0], 1'b0};
    addend = 10'd0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_dbl;
      3'b100:         addend = ~m_dbl + 10'd1;
      3'b101, 3'b110: addend = ~m_ext + 10'd1;
      default:        addend = 10'd0;
    endcase
    sum     = a_reg + addend;
    shifted = $signed({sum, q_reg, q_m1}) >>> 2;
  end

  // Datapath and registered outputs. outbus and stop are loaded on the
  // first edge spent in DONE (stop still low there), which puts the product
  // six edges after the start-sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= 10'd0;
      q_reg  <= 8'd0;
      m_reg  <= 8'd0;
      q_m1   <= 1'b0;
      count  <= 2'd0;
      outbus <= 16'h0000;
      stop   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= inbus;
          end
        end
        LOAD_Q: begin
          q_reg <= inbus;
          a_reg <= 10'd0;
          q_m1  <= 1'b0;
          count <= 2'd0;
        end
        ITER: begin
          {a_reg, q_reg, q_m1} <= shifted;
          count <= count + 2'd1;
        end
        DONE: begin
          if (!stop) begin
            outbus <= {a_reg[7:0], q_reg};
            stop   <= 1'b1;
          end else if (!start) begin
            stop <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_booth_mult.sv
// tb_radix4_booth_mult
// Self-checking bench for radix4_booth_mult: a table of fixed vectors,
// randomized operands compared with plain signed multiplication, and
// hand-written sequences for reset, latency and handshake corner cases.
module tb_radix4_booth_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  inbus;
  logic [15:0] outbus;
  logic        stop;

  int passCount;
  int checkCount;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs [7];

  radix4_booth_mult dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inbus  (inbus),
    .outbus (outbus),
    .stop   (stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the signed product of the two 8-bit operands, as 16 bits.
  function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with start held high through the result, then
  // released. Checks latency, product, stability and stop falling.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expected);
    start = 1'b1;
    inbus = a;
    tick();
    inbus = b;
    tick();
    inbus = 8'($urandom);
    repeat (3) tick();
    inbus = 8'($urandom);
    tick();
    checkOutput("stop low before 6th edge", {15'd0, stop}, 16'd0);
    tick();
    checkOutput("stop at 6th edge", {15'd0, stop}, 16'd1);
    checkOutput("product", outbus, expected);
    tick();
    checkOutput("stop held with start high", {15'd0, stop}, 16'd1);
    checkOutput("product stable", outbus, expected);
    start = 1'b0;
    tick();
    checkOutput("stop falls after start low", {15'd0, stop}, 16'd0);
    checkOutput("product retained", outbus, expected);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    passCount  = 0;
    checkCount = 0;

    vecs[0] = '{a: 8'h03, b: 8'hE9, expected: 16'hFFBB};
    vecs[1] = '{a: 8'h80, b: 8'h80, expected: 16'h4000};
    vecs[2] = '{a: 8'h7F, b: 8'h80, expected: 16'hC080};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, expected: 16'h0001};
    vecs[4] = '{a: 8'h00, b: 8'h55, expected: 16'h0000};
    vecs[5] = '{a: 8'h05, b: 8'h06, expected: 16'h001E};
    vecs[6] = '{a: 8'h07, b: 8'h6B, expected: 16'h02ED};

    rst   = 1'b1;
    start = 1'b0;
    inbus = 8'h00;
    tick();
    rst = 1'b0;
    checkOutput("reset outbus", outbus, 16'h0000);
    checkOutput("reset stop", {15'd0, stop}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle stop stays low", {15'd0, stop}, 16'd0);
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expected);
    end

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb, refProduct(ra, rb));
    end

    // Mid-operation reset: last product is nonzero, so a cleared outbus
    // proves the reset reached the output register.
    applyStimulus(8'h07, 8'h6B, 16'h02ED);
    start = 1'b1;
    inbus = 8'h09;
    tick();
    inbus = 8'h0A;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-op reset stop", {15'd0, stop}, 16'd0);
    checkOutput("mid-op reset outbus", outbus, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("no result after reset", {15'd0, stop}, 16'd0);
    end
    applyStimulus(8'h05, 8'h06, 16'h001E);

    // Start pulsed during ITER, released before the result arrives.
    start = 1'b1;
    inbus = 8'h0C;
    tick();
    inbus = 8'hF6;
    start = 1'b0;
    tick();
    start = 1'b1;
    inbus = 8'h55;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("pulse: stop low during ITER", {15'd0, stop}, 16'd0);
    end
    tick();
    checkOutput("pulse: stop at 6th edge", {15'd0, stop}, 16'd1);
    checkOutput("pulse: product", outbus, refProduct(8'h0C, 8'hF6));
    tick();
    checkOutput("pulse: stop falls", {15'd0, stop}, 16'd0);
    checkOutput("pulse: product retained", outbus, 16'hFF88);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("pulse: no retrigger", {15'd0, stop}, 16'd0);
    end
    checkOutput("pulse: product still held", outbus, 16'hFF88);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
